// File: rtl/fifo_ctrl_flags_if.sv
// Handshake and status bundle between the FIFO pointer/flag controller and
// the surrounding request logic / storage RAM.
interface fifo_ctrl_flags_if #(
  parameter int ADDR_WIDTH = 5
);
  logic                  wr;
  logic                  rd;
  logic                  flush;
  logic                  clr_err;
  logic                  wr_en;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  emp;
  logic                  full;
  logic                  almost_empty;
  logic                  almost_full;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr, rd, flush, clr_err,
    input  wr_en, rd_en, wr_addr, rd_addr, rd_ptr, wr_ptr, count,
           emp, full, almost_empty, almost_full, overflow, underflow
  );

  modport slave (
    input  wr, rd, flush, clr_err,
    output wr_en, rd_en, wr_addr, rd_addr, rd_ptr, wr_ptr, count,
           emp, full, almost_empty, almost_full, overflow, underflow
  );
endinterface

// File: rtl/fifo_ctrl_flags.sv
// Pointer and flag controller for a 2^ADDR_WIDTH-entry single-clock FIFO with
// threshold flags, occupancy count, sticky error flags and synchronous flush.
module fifo_ctrl_flags #(
  parameter int ADDR_WIDTH    = 5,
  parameter int AFULL_THRESH  = 2**ADDR_WIDTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input logic               clk,
  input logic               rst,
  fifo_ctrl_flags_if.slave  bus
);
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE_C    = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] ZERO_C   = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

  logic [ADDR_WIDTH:0] wr_ptr_r;
  logic [ADDR_WIDTH:0] rd_ptr_r;
  logic                overflow_r;
  logic                underflow_r;
  logic [ADDR_WIDTH:0] count_s;
  logic                emp_s;
  logic                full_s;
  logic                wr_en_s;
  logic                rd_en_s;
  logic                ovf_set_s;
  logic                unf_set_s;

  // Occupancy, flags and grants from the registered pointers and current requests
  always_comb begin
    count_s   = wr_ptr_r - rd_ptr_r;
    emp_s     = (count_s == ZERO_C);
    full_s    = (count_s == DEPTH_C);
    wr_en_s   = bus.wr & ~full_s & ~bus.flush & ~rst;
    rd_en_s   = bus.rd & ~emp_s & ~bus.flush & ~rst;
    ovf_set_s = bus.wr & full_s & ~bus.flush;
    unf_set_s = bus.rd & emp_s & ~bus.flush;
  end

  // Pointer registers: reset and flush both return to an empty, zero-based FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= ZERO_C;
      rd_ptr_r <= ZERO_C;
    end else if (bus.flush) begin
      wr_ptr_r <= ZERO_C;
      rd_ptr_r <= ZERO_C;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + ONE_C;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + ONE_C;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  // Sticky error flags; a new event in the clearing cycle keeps the flag set
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end else if (bus.clr_err) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
      if (unf_set_s) begin
        underflow_r <= 1'b1;
      end else if (bus.clr_err) begin
        underflow_r <= 1'b0;
      end else begin
        underflow_r <= underflow_r;
      end
    end
  end

  assign bus.wr_en        = wr_en_s;
  assign bus.rd_en        = rd_en_s;
  assign bus.wr_addr      = wr_ptr_r[ADDR_WIDTH-1:0];
  assign bus.rd_addr      = rd_ptr_r[ADDR_WIDTH-1:0];
  assign bus.wr_ptr       = wr_ptr_r;
  assign bus.rd_ptr       = rd_ptr_r;
  assign bus.count        = count_s;
  assign bus.emp          = emp_s;
  assign bus.full         = full_s;
  assign bus.almost_empty = (count_s <= AEMPTY_C);
  assign bus.almost_full  = (count_s >= AFULL_C);
  assign bus.overflow     = overflow_r;
  assign bus.underflow    = underflow_r;
endmodule

// File: tb/tb_fifo_ctrl_flags.sv
// Scoreboard bench for fifo_ctrl_flags: directed vectors push hand-computed
// expectations; a negedge monitor pops and compares the presented outputs.
module tb_fifo_ctrl_flags;
  typedef struct packed {
    logic       we;
    logic       re;
    logic [5:0] cnt;
    logic [5:0] wp;
    logic [5:0] rp;
    logic       emp;
    logic       full;
    logic       ae;
    logic       af;
    logic       ovf;
    logic       unf;
  } exp_t;

  logic clk;
  logic rst;
  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  fifo_ctrl_flags_if #(.ADDR_WIDTH(5)) bus ();

  fifo_ctrl_flags #(.ADDR_WIDTH(5), .AFULL_THRESH(30), .AEMPTY_THRESH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic we, input logic re, input int cnt,
                              input int wp, input int rp, input logic emp,
                              input logic full, input logic ae, input logic af,
                              input logic ovf, input logic unf);
    exp_t e;
    e.we = we; e.re = re;
    e.cnt = 6'(cnt); e.wp = 6'(wp); e.rp = 6'(rp);
    e.emp = emp; e.full = full; e.ae = ae; e.af = af;
    e.ovf = ovf; e.unf = unf;
    return e;
  endfunction

  task automatic step(input logic w, input logic r, input logic f, input logic c,
                      input logic rs, input exp_t e);
    @(posedge clk);
    #1;
    bus.wr = w; bus.rd = r; bus.flush = f; bus.clr_err = c; rst = rs;
    exp_q.push_back(e);
  endtask

  task automatic cmp(input int idx, input string nm, input logic [7:0] act,
                     input logic [7:0] req);
    if (act !== req) begin
      miscompares++;
      $display("FAIL vec %0d %s: got %0d, expected %0d", idx, nm, act, req);
    end
  endtask

  // Monitor: outputs are stable mid-cycle, compare against the oldest expectation
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp(vectors, "wr_en",        {7'd0, bus.wr_en},        {7'd0, e.we});
      cmp(vectors, "rd_en",        {7'd0, bus.rd_en},        {7'd0, e.re});
      cmp(vectors, "count",        {2'd0, bus.count},        {2'd0, e.cnt});
      cmp(vectors, "wr_ptr",       {2'd0, bus.wr_ptr},       {2'd0, e.wp});
      cmp(vectors, "rd_ptr",       {2'd0, bus.rd_ptr},       {2'd0, e.rp});
      cmp(vectors, "wr_addr",      {3'd0, bus.wr_addr},      {3'd0, e.wp[4:0]});
      cmp(vectors, "rd_addr",      {3'd0, bus.rd_addr},      {3'd0, e.rp[4:0]});
      cmp(vectors, "emp",          {7'd0, bus.emp},          {7'd0, e.emp});
      cmp(vectors, "full",         {7'd0, bus.full},         {7'd0, e.full});
      cmp(vectors, "almost_empty", {7'd0, bus.almost_empty}, {7'd0, e.ae});
      cmp(vectors, "almost_full",  {7'd0, bus.almost_full},  {7'd0, e.af});
      cmp(vectors, "overflow",     {7'd0, bus.overflow},     {7'd0, e.ovf});
      cmp(vectors, "underflow",    {7'd0, bus.underflow},    {7'd0, e.unf});
      vectors++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    bus.wr = 1'b0; bus.rd = 1'b0; bus.flush = 1'b0; bus.clr_err = 1'b0;
    repeat (2) @(posedge clk);

    // Fill 32 from empty: almost_full from count 30, full at 32
    for (int i = 0; i < 32; i++)
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
           mk(1'b1, 1'b0, i, i, 0, i == 0, 1'b0, i <= 2, i >= 30, 1'b0, 1'b0));
    // Full: write refused while read granted
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
         mk(1'b0, 1'b1, 32, 32, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
         mk(1'b0, 1'b0, 31, 32, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    // Drain to empty
    for (int i = 0; i < 31; i++)
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
           mk(1'b0, 1'b1, 31 - i, 32, 1 + i, 1'b0, 1'b0, (31 - i) <= 2, (31 - i) >= 30,
              1'b0, 1'b0));
    // Fill to 10, then 40 simultaneous cycles wrapping both pointers
    for (int i = 0; i < 10; i++)
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
           mk(1'b1, 1'b0, i, 32 + i, 32, i == 0, 1'b0, i <= 2, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 40; i++)
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
           mk(1'b1, 1'b1, 10, (42 + i) % 64, (32 + i) % 64, 1'b0, 1'b0, 1'b0, 1'b0,
              1'b0, 1'b0));
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
         mk(1'b0, 1'b0, 10, 18, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
           mk(1'b0, 1'b1, 10 - i, 18, 8 + i, 1'b0, 1'b0, (10 - i) <= 2, 1'b0, 1'b0, 1'b0));
    // Underflow, set-wins-over-clear, then clear
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
         mk(1'b0, 1'b0, 0, 18, 18, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
         mk(1'b0, 1'b0, 0, 18, 18, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
         mk(1'b0, 1'b0, 0, 18, 18, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
         mk(1'b0, 1'b0, 0, 18, 18, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    // Fill to 20 with underflow held, then flush with a write pending
    for (int i = 0; i < 20; i++)
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
           mk(1'b1, 1'b0, i, 18 + i, 18, i == 0, 1'b0, i <= 2, 1'b0, 1'b0, 1'b1));
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
         mk(1'b0, 1'b0, 20, 38, 18, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
         mk(1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    // Fill to 5, then reset mid-stream with both requests
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
           mk(1'b1, 1'b0, i, i, 0, i == 0, 1'b0, i <= 2, 1'b0, 1'b0, 1'b1));
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
         mk(1'b0, 1'b0, 5, 5, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
         mk(1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fifo_ctrl_flags.md
Name: fifo_ctrl_flags

Overview:
- Parametrised pointer/flag controller for a 2^ADDR_WIDTH-entry single-clock FIFO; drives an external dual-port RAM through address and enable outputs.
- Next generation of the basic FIFO controller:
  - same-cycle read and write are legal;
  - programmable almost-full and almost-empty thresholds;
  - occupancy count output;
  - sticky overflow and underflow error flags;
  - synchronous flush.
- Sits between producer/consumer request logic and the storage RAM.

Parameters:
- ADDR_WIDTH, 5, RAM address width; FIFO depth DEPTH = 2^ADDR_WIDTH entries.
- AFULL_THRESH, 2^ADDR_WIDTH-2, almost_full asserts when count >= this value; legal range 1..DEPTH.
- AEMPTY_THRESH, 2, almost_empty asserts when count <= this value; legal range 0..DEPTH-1.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- wr  in  1  write request from producer.
- rd  in  1  read request from consumer.
- flush  in  1  synchronous empty-the-FIFO command.
- clr_err  in  1  clears the sticky error flags.
- wr_en  out  1  write grant; RAM write strobe, same cycle as wr.
- rd_en  out  1  read grant; RAM read strobe, same cycle as rd.
- wr_addr  out  ADDR_WIDTH  RAM write address, equal to wr_ptr[ADDR_WIDTH-1:0].
- rd_addr  out  ADDR_WIDTH  RAM read address, equal to rd_ptr[ADDR_WIDTH-1:0].
- rd_ptr  out  ADDR_WIDTH+1  read pointer, including the wrap bit.
- wr_ptr  out  ADDR_WIDTH+1  write pointer, including the wrap bit.
- count  out  ADDR_WIDTH+1  occupancy, 0..DEPTH.
- emp  out  1  FIFO empty (count == 0).
- full  out  1  FIFO full (count == DEPTH).
- almost_empty  out  1  count <= AEMPTY_THRESH.
- almost_full  out  1  count >= AFULL_THRESH.
- overflow  out  1  sticky flag: a write was refused because the FIFO was full.
- underflow  out  1  sticky flag: a read was refused because the FIFO was empty.

Behaviour:
- Reset (rst=1 at the clock edge):
  - rd_ptr = wr_ptr = 0, so count = 0, emp = 1, full = 0, almost_empty = 1, almost_full = 0.
  - overflow = underflow = 0.
  - rst overrides every other input in that cycle.
  - Reset asserted mid-stream discards all contents; no grant is issued in a reset cycle.
- Count and flags:
  - count = wr_ptr - rd_ptr, computed modulo 2^(ADDR_WIDTH+1).
  - All flags are combinational from the registered pointers, so they are valid in the cycle after a pointer update.
- Write grant: wr_en = wr & ~full & ~flush & ~rst. On wr_en, wr_ptr increments by 1 at the clock edge, wrapping 2^(ADDR_WIDTH+1)-1 -> 0.
- Read grant: rd_en = rd & ~emp & ~flush & ~rst. On rd_en, rd_ptr increments by 1 at the clock edge, with the same wrap.
- Grants use current-cycle flags only:
  - when full, a write is refused even if a read is granted in the same cycle;
  - when empty, a read is refused even if a write is granted in the same cycle;
  - there is no bypass path.
- Simultaneous rd_en and wr_en: both pointers advance; count, emp and full are unchanged.
- Read data latency is owned by the RAM; this block only issues rd_en and rd_addr.
- Flush (flush=1, rst=0): at the edge, rd_ptr and wr_ptr both go to 0.
  - Grants are forced low in the flush cycle.
  - Error flags are unaffected.
- Overflow: overflow is set at the edge when wr & full & ~flush.
- Underflow: underflow is set at the edge when rd & emp & ~flush.
- Error clearing:
  - clr_err=1 clears both sticky flags at the edge.
  - If a new error event occurs in the same cycle as clr_err, the flag is set (set wins over clear).
- Thresholds: almost_full and almost_empty may both be high at once for small DEPTH; this is legal.

Test Plan:
- Reset, then 32 writes (ADDR_WIDTH=5) with rd=0 -> wr_en high on every write; afterwards full=1, count=32, wr_ptr=6'b100000, wr_addr=0; almost_full has been high since count reached 30.
- From full: one cycle with wr=1, rd=1 -> rd_en=1, wr_en=0, overflow=1; next cycle count=31, full=0.
- Fill to 10, then 40 cycles of wr=1, rd=1 -> count stays 10 throughout; both pointers wrap past 63 -> 0; no error flags set.
- From empty: rd=1 -> rd_en=0, underflow=1. Then clr_err=1 together with rd=1 while still empty -> underflow remains 1. Then clr_err=1 alone -> underflow=0.
- Fill to 20, then flush=1 with wr=1 -> wr_en=0; next cycle rd_ptr=wr_ptr=0, emp=1, almost_empty=1; overflow and underflow keep their prior values.
- Fill to 5, assert rst with rd=1 and wr=1 -> no grants in that cycle; next cycle count=0, emp=1, both error flags 0.
